fetch_sequencer: RTL and testbench

Program-counter sequencer that drives the address port of `instruction_memory` and delivers fetched words to decode over a valid/ready handshake. It owns the PC, handles backpressure, redirects and program termination, and counts delivered instructions. It sits between `instruction_memory` (combinational read) and the decode stage of the single-cycle core.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/sat_counter.sv | 51 +++++
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch sequencer: FSM state encoding, the default
// terminator instruction and the instruction size in bytes, plus a helper that
// forces a byte address onto a word boundary.
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES       = 4;

    // Clear the byte-offset bits so the PC always names a whole word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset (count -> 0)
//   clr_i   in   synchronous clear, wins over inc_i
//   inc_i   in   add one unless already saturated
//   count_o out  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = CNT_ZERO;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter, drives the instruction memory address and hands
// fetched words to decode over a valid/ready handshake. Handles backpressure,
// redirects, program termination (terminator word or end of memory) and
// counts delivered instructions.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             pulse: begin fetching at RESET_PC (IDLE/HALT only)
//   imem_addr         byte address presented to instruction memory (= PC)
//   imem_instr        word returned combinationally for imem_addr
//   out_valid/ready   handshake towards decode
//   out_instr/out_pc  delivered instruction and its byte address
//   redirect_valid/pc one-cycle PC change request (FETCH/HALT only)
//   halted            high while in HALT
//   misalign          sticky: a redirect target had nonzero bits [1:0]
//   retired           saturating count of handshakes since start
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PROG_WORDS = 256,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        misalign,
    output logic [15:0] retired
);

    localparam logic [31:0] PC_LIMIT = 32'(PROG_WORDS * INSTR_BYTES);
    localparam logic [31:0] PC_STEP  = 32'(INSTR_BYTES);

    state_e      state_q;
    logic [31:0] pc_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic        halted_q;
    logic        misalign_q;

    logic        redirect_take;
    logic        start_take;
    logic        accept;
    logic        advance;
    logic        stop_fetch;

    // Request decoding in priority order: redirect beats start, and both only
    // apply in the states where they are meaningful.
    always_comb begin
        redirect_take = redirect_valid && (state_q != IDLE);
        start_take    = start && !redirect_take && (state_q != FETCH);
        accept        = out_valid_q && out_ready;
        advance       = (state_q == FETCH) && (!out_valid_q || out_ready);
        // The limit test runs on the PC itself, so an overrun is caught before
        // the PC could wrap past 2^32.
        stop_fetch    = (pc_q >= PC_LIMIT) || (imem_instr == HALT_WORD);
    end

    // Sequencer FSM with its registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            out_pc_q    <= 32'h0000_0000;
            halted_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (redirect_take) begin
            // Whatever was held or in flight is dropped; the target word is
            // fetched on the following edge.
            state_q     <= FETCH;
            pc_q        <= align_word(redirect_pc);
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end else begin
                misalign_q <= misalign_q;
            end
        end else if (start_take) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (advance) begin
                        if (stop_fetch) begin
                            // The PC stays on the terminator / limit address.
                            state_q     <= HALT;
                            out_valid_q <= 1'b0;
                            halted_q    <= 1'b1;
                        end else begin
                            out_instr_q <= imem_instr;
                            out_pc_q    <= pc_q;
                            out_valid_q <= 1'b1;
                            pc_q        <= pc_q + PC_STEP;
                        end
                    end else begin
                        // Backpressure: output word and PC are frozen.
                        out_valid_q <= out_valid_q;
                    end
                end
                IDLE: begin
                    out_valid_q <= 1'b0;
                end
                HALT: begin
                    out_valid_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    pc_q        <= RESET_PC;
                    out_valid_q <= 1'b0;
                    halted_q    <= 1'b0;
                end
            endcase
        end
    end

    // A handshake coinciding with a redirect still counts: decode took the word.
    sat_counter #(
        .WIDTH (16)
    ) u_retired (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (start_take),
        .inc_i   (accept),
        .count_o (retired)
    );

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. A behavioural model of the sequencer's
// rules runs beside the main DUT and is compared every cycle; hand-computed
// literals pin both the model and the DUT at the interesting points. A second
// instance with a 4-word memory exercises the end-of-memory stop.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset          = 1'b0;
    logic        start          = 1'b0;
    logic        out_ready      = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0000_0000;
    logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid, halted, misalign;
    logic [15:0] retired;

    logic        start4          = 1'b0;
    logic        out_ready4      = 1'b1;
    logic        redirect_valid4 = 1'b0;
    logic [31:0] redirect_pc4    = 32'h0000_0000;
    logic [31:0] imem_addr4, imem_instr4, out_instr4, out_pc4;
    logic        out_valid4, halted4, misalign4;
    logic [15:0] retired4;

    logic [31:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 1'b0;

    assign imem_instr  = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hFFFF_FFFF;
    assign imem_instr4 = 32'h5000_0000 | imem_addr4;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .misalign(misalign), .retired(retired)
    );

    fetch_sequencer #(.PROG_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .imem_addr(imem_addr4), .imem_instr(imem_instr4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_instr(out_instr4), .out_pc(out_pc4),
        .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
        .halted(halted4), .misalign(misalign4), .retired(retired4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a < 32'd1024) return mem[a[9:2]];
        else return 32'hFFFF_FFFF;
    endfunction

    // ---------------- behavioural model ----------------
    // m_mode: 0 not started, 1 running, 2 stopped. m_hs_q lists delivered PCs.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_opc;
    bit          m_valid, m_halted, m_mis;
    int          m_ret;
    logic [31:0] m_hs_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_pc <= 32'h0; m_valid <= 1'b0; m_instr <= 32'h0;
            m_opc <= 32'h0; m_halted <= 1'b0; m_mis <= 1'b0; m_ret <= 0;
            m_hs_q.delete();
        end else begin
            if (m_valid && out_ready) begin
                m_ret <= (m_ret >= 65535) ? 65535 : m_ret + 1;
                m_hs_q.push_back(m_opc);
            end
            if (redirect_valid && m_mode != 0) begin
                m_pc <= redirect_pc & 32'hFFFF_FFFC;
                m_valid <= 1'b0; m_mode <= 1; m_halted <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) m_mis <= 1'b1;
            end else if (start && m_mode != 1) begin
                m_mode <= 1; m_pc <= 32'h0; m_valid <= 1'b0; m_halted <= 1'b0;
                m_mis <= 1'b0; m_ret <= 0;
                m_hs_q.delete();
            end else if (m_mode == 1 && (!m_valid || out_ready)) begin
                if (m_pc >= 32'd1024 || mem_read(m_pc) == 32'h0) begin
                    m_mode <= 2; m_valid <= 1'b0; m_halted <= 1'b1;
                end else begin
                    m_instr <= mem_read(m_pc); m_opc <= m_pc;
                    m_valid <= 1'b1; m_pc <= m_pc + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison of the main DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_imem_addr", imem_addr, m_pc);
            check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            check("cyc_halted", 32'(halted), 32'(m_halted));
            check("cyc_misalign", 32'(misalign), 32'(m_mis));
            check("cyc_retired", 32'(retired), 32'(m_ret));
            if (m_valid) begin
                check("cyc_out_instr", out_instr, m_instr);
                check("cyc_out_pc", out_pc, m_opc);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        for (int n = 0; n < 60 && !halted; n++) @(negedge clk);
        check(name, 32'(halted), 32'd1);
    endtask

    task automatic wait_valid_pc(input string name, input logic [31:0] pc);
        for (int n = 0; n < 30 && !(out_valid && out_pc == pc); n++) @(negedge clk);
        check(name, 32'(out_valid && out_pc == pc), 32'd1);
    endtask

    logic [31:0] redir_seq [0:7] = '{32'h00, 32'h04, 32'h08, 32'h0C,
                                     32'h20, 32'h24, 32'h28, 32'h2C};
    logic [31:0] seen4[$];
    logic [31:0] first4;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[12] = 32'h0000_0000;

        // Reset values
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        cmp_en = 1'b1;

        // Straight-line run to the terminator at 0x30
        @(negedge clk);
        pulse_start();
        check("lat_first_invalid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_first_valid", 32'(out_valid), 32'd1);
        check("lat_first_pc", out_pc, 32'h0);
        wait_halt("run_halt");
        check("run_retired", 32'(retired), 32'd12);
        check("run_imem_addr", imem_addr, 32'h30);
        check("run_seq_len", 32'(m_hs_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < m_hs_q.size(); i++)
            check("run_seq_pc", m_hs_q[i], 32'(i * 4));

        // Backpressure on the word at 0x08
        pulse_start();
        wait_valid_pc("bp_reach", 32'h08);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_pc", out_pc, 32'h08);
            check("bp_out_instr", out_instr, 32'hA000_0002);
            check("bp_imem_addr", imem_addr, 32'h0C);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        wait_halt("bp_halt");
        check("bp_retired", 32'(retired), 32'd12);
        check("bp_seq_len", 32'(m_hs_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < m_hs_q.size(); i++)
            check("bp_seq_pc", m_hs_q[i], 32'(i * 4));

        // Redirect while the word at 0x10 is held
        pulse_start();
        wait_valid_pc("rd_reach", 32'h10);
        out_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("rd_flush", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rd_target_valid", 32'(out_valid), 32'd1);
        check("rd_target_pc", out_pc, 32'h20);
        wait_halt("rd_halt");
        check("rd_retired", 32'(retired), 32'd8);
        check("rd_seq_len", 32'(m_hs_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < m_hs_q.size(); i++)
            check("rd_seq_pc", m_hs_q[i], redir_seq[i]);

        // Misaligned redirect from HALT
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_pc", imem_addr, 32'h20);
        check("mis_not_halted", 32'(halted), 32'd0);
        @(negedge clk);
        check("mis_target_pc", out_pc, 32'h20);
        wait_halt("mis_halt");
        check("mis_sticky", 32'(misalign), 32'd1);
        check("mis_retired", 32'(retired), 32'd12);
        pulse_start();
        check("mis_cleared", 32'(misalign), 32'd0);
        check("mis_retired_clr", 32'(retired), 32'd0);

        // Asynchronous reset mid-run after 5 handshakes
        for (int n = 0; n < 30 && retired != 16'd5; n++) @(negedge clk);
        check("ar_reach", 32'(retired), 32'd5);
        #2 reset = 1'b1;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_retired", 32'(retired), 32'd0);
        check("ar_imem_addr", imem_addr, 32'h0);
        check("ar_out_pc", out_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("ar_idle_valid", 32'(out_valid), 32'd0);
        check("ar_idle_addr", imem_addr, 32'h0);
        check("ar_idle_halted", 32'(halted), 32'd0);

        // End-of-memory stop on the 4-word instance
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        first4 = 32'h0;
        for (int n = 0; n < 30 && !halted4; n++) begin
            if (out_valid4 && out_ready4) begin
                if (seen4.size() == 0) first4 = out_instr4;
                seen4.push_back(out_pc4);
            end
            @(negedge clk);
        end
        check("lim_halted", 32'(halted4), 32'd1);
        check("lim_count", 32'(seen4.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen4.size(); i++)
            check("lim_seq_pc", seen4[i], 32'(i * 4));
        check("lim_first_instr", first4, 32'h5000_0000);
        check("lim_imem_addr", imem_addr4, 32'h10);
        check("lim_retired", 32'(retired4), 32'd4);
        check("lim_misalign", 32'(misalign4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
